// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Purpose  : Fetch / execute / write-back sequencer for a simple 16-bit core.
//            Fetches instruction words into the IR, advances the PC, and emits
//            datapath strobes gated by the external decoder's enables.
// Options  : EXEC_SEQUENCER_RETIRE_CNT_EN adds a saturating retired-instruction
//            counter on output retire_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        pc_clr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic [1:0]  cu_inst_type,
    input  logic        cu_reg_read,
    input  logic        cu_alu_enable,
    input  logic        cu_reg_write,
    output logic        imem_req,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic [5:0]  opcode,
    output logic        rf_read_en,
    output logic        alu_go,
    output logic        rf_write_en,
    output logic [1:0]  state,
`ifdef EXEC_SEQUENCER_RETIRE_CNT_EN
    output logic [15:0] retire_cnt,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WB    = 2'b11
    } state_t;

    localparam logic [5:0] c_HALT_OPCODE = 6'b111111;
    localparam logic [1:0] c_NOP_TYPE    = 2'b00;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;

    logic        w_is_halt;
    logic        w_is_nop;

    assign w_is_halt = (r_ir[15:10] == c_HALT_OPCODE);
    assign w_is_nop  = (cu_inst_type == c_NOP_TYPE);

    // Sequencer state, program counter and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= 8'd0;
            r_ir    <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_clr) begin
                        r_pc <= 8'd0;
                    end
                    if (run) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Once a fetch has started it runs to completion; run is
                    // only re-examined at instruction boundaries.
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_halt) begin
                        r_state <= ST_IDLE;
                    end else if (w_is_nop) begin
                        r_state <= run ? ST_FETCH : ST_IDLE;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_state <= run ? ST_FETCH : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EXEC_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;
    logic        w_retire;

    // An instruction retires when it leaves WB, or leaves EXEC as a NOP.
    // HALT is checked first so it never counts, even if decoded as NOP class.
    assign w_retire = (r_state == ST_WB) ||
                      ((r_state == ST_EXEC) && !w_is_halt && w_is_nop);

    // Saturating retired-instruction counter, cleared alongside the PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && pc_clr) begin
            r_retire_cnt <= 16'd0;
        end else if (w_retire && (r_retire_cnt != 16'hFFFF)) begin
            r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

    // Datapath strobes follow the state directly so EXEC/WB act in-cycle
    always_comb begin
        rf_read_en  = 1'b0;
        alu_go      = 1'b0;
        rf_write_en = 1'b0;
        case (r_state)
            ST_EXEC: begin
                rf_read_en = cu_reg_read;
                alu_go     = cu_alu_enable;
            end
            ST_WB: begin
                rf_write_en = cu_reg_write;
            end
            default: begin
                rf_read_en  = 1'b0;
                alu_go      = 1'b0;
                rf_write_en = 1'b0;
            end
        endcase
    end

    assign imem_req = (r_state == ST_FETCH);
    assign busy     = (r_state != ST_IDLE);
    assign state    = r_state;
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign opcode   = r_ir[15:10];

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 run  in  1  level enable; 1 = fetch/execute instructions.
REQ-005 pc_clr  in  1  synchronous PC clear; honoured in IDLE only.
REQ-006 imem_valid  in  1  instruction word valid, qualifies imem_rdata.
REQ-007 imem_rdata  in  16  instruction word; opcode = bits [15:10].
REQ-008 cu_inst_type  in  2  from decoder; 2'b00 = NOP class.
REQ-009 cu_reg_read  in  1  OR of the decoder's two register-read enables.
REQ-010 cu_alu_enable, cu_reg_write  in  1 each  decoder enables.
REQ-011 imem_req  out  1  fetch request, high throughout FETCH.
REQ-012 pc  out  8  address of the next instruction to fetch.
REQ-013 ir  out  16  instruction register; opcode  out  6  = ir[15:10], fed to the decoder.
REQ-014 rf_read_en, alu_go, rf_write_en  out  1 each  gated datapath strobes.
REQ-015 state  out  2  IDLE=00, FETCH=01, EXEC=10, WB=11; busy  out  1  = (state != IDLE).

Function
REQ-016 IDLE: run=1 -> FETCH next edge; else stay; pc_clr=1 sets pc to 0 (pc_clr ignored in other states).
REQ-017 FETCH: imem_req=1; on edge with imem_valid=1: ir <= imem_rdata, pc <= pc+1 (255 wraps to 0), -> EXEC; imem_valid=0 holds FETCH indefinitely.
REQ-018 FETCH completes even if run drops before imem_valid; imem_valid outside FETCH is ignored.
REQ-019 EXEC (exactly 1 cycle): rf_read_en = cu_reg_read, alu_go = cu_alu_enable; rf_write_en=0.
REQ-020 EXEC exit: opcode 6'b111111 (HALT) -> IDLE; else cu_inst_type=00 (NOP) -> FETCH if run else IDLE; else -> WB.
REQ-021 WB (exactly 1 cycle): rf_write_en = cu_reg_write; rf_read_en=alu_go=0; exit -> FETCH if run else IDLE.
REQ-022 All strobes are 0 in IDLE and FETCH; strobes are combinational from state and decoder inputs, no added latency.
REQ-023 Throughput: 3 cycles per non-NOP instruction and 2 per NOP, with zero memory wait.
REQ-024 HALT leaves pc pointing past the HALT word; a later run=1 resumes from there.
REQ-025 ir holds its value in every state except the FETCH accept edge.

Reset
REQ-026 rst_n=0 immediately forces state=IDLE, pc=0, ir=0, all strobes and imem_req=0, busy=0, regardless of state (mid-fetch or mid-instruction work is discarded).
REQ-027 The first possible FETCH is the first rising edge after rst_n deasserts with run=1.

Configuration
REQ-028 Macro EXEC_SEQUENCER_RETIRE_CNT_EN defined: extra output retire_cnt[15:0], reset 0, +1 at each WB exit and NOP EXEC exit, saturating at 16'hFFFF; HALT not counted; cleared by pc_clr in IDLE.
REQ-029 Macro undefined: no retire_cnt port or logic; all other behaviour identical.

Verification
REQ-030 Reset, run=1, imem_valid=1, word 16'h0400 (opcode 000001, type 01, write=1) -> states 01,10,11,01; pc 0->1; rf_write_en=1 only in WB.
REQ-031 Word opcode 000000 (type 00) -> FETCH->EXEC->FETCH, no WB; rf_write_en never 1; retire_cnt +1 when enabled.
REQ-032 Word 16'hFC00 (HALT) at pc=5 -> EXEC->IDLE, pc=6, busy=0, retire_cnt unchanged; run stays 1 -> re-FETCH at pc=6.
REQ-033 imem_valid held 0 for 4 cycles in FETCH with run dropped -> stays FETCH, imem_req=1; valid=1 -> EXEC, WB, then IDLE.
REQ-034 pc=255 fetch accepted -> pc=0; rst_n pulsed low during WB -> same-cycle IDLE, pc=0, rf_write_en=0.
REQ-035 pc_clr=1 in EXEC -> pc unchanged; pc_clr=1 in IDLE -> pc=0 next edge.
